// File: rtl/tt_um_loopback_tester.sv
// -----------------------------------------------------------------------------
// tt_um_loopback_tester
//
// Loopback and self-check user module for the multiplexer connectivity flow.
// A 2-bit mode selects what is sent back out through the mux:
//   0 direct     : uo_out = ui_in (combinational, zero latency)
//   1 registered : uo_out = ui_in delayed by one enabled cycle
//   2 delayed    : uo_out = ui_in delayed by DELAY enabled cycles
//   3 generator  : uo_out = 8-bit Galois LFSR. The harness returns uo_out
//                  registered once on ui_in, and each returned byte is compared
//                  with the previous LFSR value. Mismatches count into a
//                  saturating 4-bit error counter.
//
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   ena      design enable from the mux; every register holds while low
//   ui_in    loopback data, or the returned LFSR byte in mode 3
//   uo_out   loopback or LFSR data
//   uio_in   [1:0] mode select, [2] synchronous error clear, [7:3] unused
//   uio_out  [7:4] error count, [3:0] zero
//   uio_oe   constant 8'hF0 (upper nibble driven, lower nibble input)
// -----------------------------------------------------------------------------
module tt_um_loopback_tester #(
  parameter int          DELAY     = 4,
  parameter logic [7:0]  LFSR_SEED = 8'h01,
  parameter logic [7:0]  LFSR_TAPS = 8'hB8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  generate
    if (DELAY < 1 || DELAY > 16) begin : g_bad_delay
      $error("tt_um_loopback_tester: DELAY must be in 1..16");
    end
    if (LFSR_SEED == 8'h00) begin : g_bad_seed
      $error("tt_um_loopback_tester: LFSR_SEED must be non-zero");
    end
  endgenerate

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'd0,
    MODE_REG    = 2'd1,
    MODE_DELAY  = 2'd2,
    MODE_LFSR   = 2'd3
  } mode_e;

  mode_e                  mode_q;
  mode_e                  mode_d;
  logic [7:0]             reg_q;
  logic [DELAY-1:0][7:0]  tap_q;
  logic [7:0]             lfsr_q;
  logic [7:0]             lfsr_prev_q;
  logic [7:0]             lfsr_next;
  logic                   chk_valid_q;
  logic [3:0]             err_cnt_q;
  logic                   err_clr;
  logic                   chk_fail;
  logic                   unused_bits;

  assign mode_d  = mode_e'(uio_in[1:0]);
  assign err_clr = uio_in[2];

  // uio_in[7:3] carry nothing for this design.
  assign unused_bits = &{1'b0, uio_in[7:3]};

  // Galois step: shift right, fold the mask in when a one falls off the end.
  assign lfsr_next = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 8'h00);

  // The returned byte is the LFSR value from one cycle back, because the
  // harness registers uo_out once before feeding it to ui_in.
  assign chk_fail = (mode_q == MODE_LFSR) && chk_valid_q && (ui_in != lfsr_prev_q);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= MODE_DIRECT;
      reg_q       <= '0;
      // NOTE: the delay line is a small register array, not a RAM, so it is
      // reset along with everything else; mode 2 then emits zeros, not X.
      tap_q       <= '0;
      lfsr_q      <= LFSR_SEED;
      lfsr_prev_q <= '0;
      chk_valid_q <= 1'b0;
      err_cnt_q   <= '0;
    end else if (ena) begin
      mode_q <= mode_d;
      reg_q  <= ui_in;

      // The delay line always shifts, so mode 2 is valid as soon as it is selected.
      tap_q[0] <= ui_in;
      for (int i = 1; i < DELAY; i++) begin
        tap_q[i] <= tap_q[i-1];
      end

      if (mode_d == MODE_LFSR) begin
        if (mode_q != MODE_LFSR) begin
          // Entering mode 3: restart the sequence; the first returned byte
          // is not yet meaningful, so checking waits one cycle.
          lfsr_q      <= LFSR_SEED;
          chk_valid_q <= 1'b0;
        end else begin
          lfsr_q      <= lfsr_next;
          lfsr_prev_q <= lfsr_q;
          chk_valid_q <= 1'b1;
        end
      end else begin
        // Leaving (or outside) mode 3: the LFSR holds its value.
        chk_valid_q <= 1'b0;
      end

      // Clear wins over a same-cycle mismatch; the count sticks at 15.
      if (err_clr) begin
        err_cnt_q <= '0;
      end else if (chk_fail && (err_cnt_q != 4'hF)) begin
        err_cnt_q <= err_cnt_q + 4'd1;
      end
    end
  end

  // NOTE: uo_out is assigned a default before the case so no path through the
  // block leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    uo_out = ui_in;
    unique case (mode_q)
      MODE_DIRECT: uo_out = ui_in;
      MODE_REG:    uo_out = reg_q;
      MODE_DELAY:  uo_out = tap_q[DELAY-1];
      MODE_LFSR:   uo_out = lfsr_q;
      default:     uo_out = ui_in;
    endcase
  end

  assign uio_out = {err_cnt_q, 4'h0};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_loopback_tester.sv
// -----------------------------------------------------------------------------
// Testbench for tt_um_loopback_tester (DELAY=4, LFSR_SEED=01, LFSR_TAPS=B8).
// The reference model keeps the input history as an array, the LFSR as an
// index into a precomputed maximal-length sequence, and the error count as a
// plain integer. A harness register gated by ena models the once-registered
// return path used in mode 3.
// -----------------------------------------------------------------------------
module tb_tt_um_loopback_tester;

  localparam int         DELAY = 4;
  localparam logic [7:0] SEED  = 8'h01;
  localparam logic [7:0] TAPS  = 8'hB8;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       ena    = 1'b0;
  logic [7:0] ui_in  = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  tt_um_loopback_tester #(
    .DELAY    (DELAY),
    .LFSR_SEED(SEED),
    .LFSR_TAPS(TAPS)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // ---------------- reference model ----------------
  logic [7:0] seq [255];     // seq[k] = LFSR value k steps after the seed
  int         m_mode;
  int         m_k;           // position of the live LFSR value in seq
  int         m_err;
  bit         m_chk;
  logic [7:0] m_prev;        // value the returned byte must equal
  logic [7:0] m_reg;
  logic [7:0] m_hist [16];   // m_hist[0] = most recent enabled input
  logic [7:0] ret_q;         // harness return register
  logic [7:0] pre_uo;

  function automatic logic [7:0] galois(input logic [7:0] x);
    return (x >> 1) ^ (x[0] ? TAPS : 8'h00);
  endfunction

  function automatic void build_seq();
    seq[0] = SEED;
    for (int i = 1; i < 255; i++) seq[i] = galois(seq[i-1]);
  endfunction

  function automatic void model_reset();
    m_mode = 0; m_k = 0; m_err = 0; m_chk = 1'b0; m_prev = 8'h00; m_reg = 8'h00;
    for (int i = 0; i < 16; i++) m_hist[i] = 8'h00;
    ret_q = 8'h00;
  endfunction

  function automatic logic [7:0] exp_uo();
    case (m_mode)
      0:       return ui_in;
      1:       return m_reg;
      2:       return m_hist[DELAY-1];
      default: return seq[m_k];
    endcase
  endfunction

  function automatic logic [7:0] exp_uio();
    return {4'(m_err), 4'h0};
  endfunction

  // Applies the effect of one clock edge given the inputs present at it.
  function automatic void model_edge();
    int nm;
    bit mism;
    if (!ena || !rst_n) return;
    nm   = int'(uio_in[1:0]);
    mism = (m_mode == 3) && m_chk && (ui_in != m_prev);
    if (uio_in[2])  m_err = 0;
    else if (mism)  m_err = (m_err < 15) ? m_err + 1 : 15;
    for (int i = 15; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = ui_in;
    m_reg     = ui_in;
    if (nm == 3) begin
      if (m_mode != 3) begin
        m_k = 0; m_chk = 1'b0;
      end else begin
        m_prev = seq[m_k]; m_k = (m_k + 1) % 255; m_chk = 1'b1;
      end
    end else begin
      m_chk = 1'b0;
    end
    m_mode = nm;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic e, input logic [7:0] ui, input logic [7:0] uio);
    ena = e; ui_in = ui; uio_in = uio;
    #1;
  endtask

  task automatic step();
    pre_uo = uo_out;
    @(posedge clk);
    if (ena && rst_n) ret_q = pre_uo;
    model_edge();
    #1;
    cyc++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive(1'b1, 8'hA5, 8'h03);
    n_vec++;
    if (uio_oe !== 8'hF0) begin n_err++; $display("FAIL reset_oe got=%h exp=F0", uio_oe); end
    n_vec++;
    if (uio_out !== 8'h00) begin n_err++; $display("FAIL reset_uio got=%h exp=00", uio_out); end
    n_vec++;
    if (uo_out !== 8'hA5) begin n_err++; $display("FAIL reset_uo got=%h exp=A5", uo_out); end
    @(negedge clk);
    rst_n = 1'b1;
    uio_in = 8'h00;
    step();
  endtask

  task automatic test_direct();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) begin
      v = (i == 0) ? 8'hA5 : 8'($urandom);
      drive(1'b1, v, 8'h00);
      n_vec++;
      if (uo_out !== v) begin n_err++; $display("FAIL direct cyc=%0d got=%h exp=%h", cyc, uo_out, v); end
      step();
    end
  endtask

  task automatic test_registered();
    logic [7:0] v;
    drive(1'b1, 8'h00, 8'h01);
    step();
    for (int i = 0; i < 8; i++) begin
      case (i)
        0: v = 8'h11;
        1: v = 8'h22;
        2: v = 8'h33;
        default: v = 8'($urandom);
      endcase
      drive(1'b1, v, 8'h01);
      n_vec++;
      if (uo_out !== exp_uo()) begin n_err++; $display("FAIL registered cyc=%0d got=%h exp=%h", cyc, uo_out, exp_uo()); end
      step();
    end
  endtask

  task automatic test_delayed();
    logic [7:0] want;
    for (int i = 0; i < DELAY + 2; i++) begin
      drive(1'b1, 8'h00, 8'h02);
      step();
    end
    drive(1'b1, 8'h5A, 8'h02);
    n_vec++;
    if (uo_out !== 8'h00) begin n_err++; $display("FAIL delay_pre got=%h exp=00", uo_out); end
    step();
    for (int i = 1; i <= DELAY + 3; i++) begin
      drive(1'b1, 8'h00, 8'h02);
      want = (i == DELAY) ? 8'h5A : 8'h00;
      n_vec++;
      if (uo_out !== want) begin n_err++; $display("FAIL delay_pulse offset=%0d got=%h exp=%h", i, uo_out, want); end
      step();
    end
  endtask

  task automatic test_lfsr();
    bit seen [256];
    int distinct;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    drive(1'b1, ret_q, 8'h03);
    step();
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, ret_q, 8'h03);
      n_vec++;
      if (uo_out !== exp_uo()) begin n_err++; $display("FAIL lfsr_seq cyc=%0d got=%h exp=%h", cyc, uo_out, exp_uo()); end
      seen[int'(uo_out)] = 1'b1;
      step();
    end
    distinct = 0;
    for (int i = 1; i < 256; i++) if (seen[i]) distinct++;
    n_vec++;
    if (distinct != 255 || seen[0]) begin
      n_err++; $display("FAIL lfsr_distinct got=%0d zero_seen=%0b exp=255", distinct, seen[0]);
    end
    n_vec++;
    if (uio_out !== 8'h00) begin n_err++; $display("FAIL lfsr_err_zero got=%h exp=00", uio_out); end
  endtask

  task automatic test_stuck_and_clear();
    for (int i = 0; i < 80; i++) begin
      drive(1'b1, ret_q | 8'h01, 8'h03);
      n_vec++;
      if (uio_out !== exp_uio()) begin n_err++; $display("FAIL stuck_err cyc=%0d got=%h exp=%h", cyc, uio_out, exp_uio()); end
      step();
    end
    drive(1'b1, ret_q, 8'h03);
    n_vec++;
    if (uio_out !== 8'hF0) begin n_err++; $display("FAIL stuck_saturate got=%h exp=F0", uio_out); end
    // Clear together with a guaranteed mismatch.
    drive(1'b1, ~m_prev, 8'h07);
    step();
    drive(1'b1, ret_q, 8'h03);
    n_vec++;
    if (uio_out !== 8'h00) begin n_err++; $display("FAIL clear_priority got=%h exp=00", uio_out); end
    step();
  endtask

  task automatic test_ena_hold();
    logic [7:0] held_uo;
    for (int i = 0; i < 5; i++) begin drive(1'b1, ret_q, 8'h03); step(); end
    held_uo = exp_uo();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 8'($urandom), 8'($urandom));
      n_vec++;
      if (uo_out !== held_uo) begin n_err++; $display("FAIL hold_lfsr cyc=%0d got=%h exp=%h", cyc, uo_out, held_uo); end
      step();
    end
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, ret_q, 8'h03);
      n_vec++;
      if (uo_out !== exp_uo() || uio_out !== 8'h00) begin
        n_err++; $display("FAIL resume cyc=%0d uo=%h exp=%h uio=%h exp=00", cyc, uo_out, exp_uo(), uio_out);
      end
      step();
    end
    for (int i = 0; i < 10; i++) begin drive(1'b0, 8'($urandom), 8'h06); step(); end
    for (int i = 0; i < DELAY + 3; i++) begin
      drive(1'b1, 8'($urandom), 8'h02);
      n_vec++;
      if (uo_out !== exp_uo()) begin n_err++; $display("FAIL hold_delay cyc=%0d got=%h exp=%h", cyc, uo_out, exp_uo()); end
      step();
    end
  endtask

  task automatic test_random();
    int md;
    logic [7:0] v;
    logic [7:0] u;
    logic e;
    md = 3;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 24) == 0) md = $urandom_range(0, 3);
      e = ($urandom_range(0, 9) != 0);
      if (m_mode == 3) v = ($urandom_range(0, 9) == 0) ? ret_q ^ 8'($urandom_range(1, 255)) : ret_q;
      else             v = 8'($urandom);
      u = {3'($urandom), 1'b0, ($urandom_range(0, 29) == 0), 2'(md)};
      drive(e, v, u);
      n_vec++;
      if (uo_out !== exp_uo() || uio_out !== exp_uio() || uio_oe !== 8'hF0) begin
        n_err++;
        $display("FAIL random cyc=%0d uo=%h exp=%h uio=%h exp=%h oe=%h", cyc, uo_out, exp_uo(), uio_out, exp_uio(), uio_oe);
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, ret_q, 8'h00);
    step();
    drive(1'b1, ret_q, 8'h03);
    step();
    for (int i = 0; i < 6; i++) begin drive(1'b1, ~m_prev, 8'h03); step(); end
    n_vec++;
    if (uio_out !== exp_uio() || m_err == 0) begin
      n_err++; $display("FAIL pre_reset_err got=%h exp=%h", uio_out, exp_uio());
    end
    ui_in = 8'h3C;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if (uo_out !== 8'h3C || uio_out !== 8'h00 || uio_oe !== 8'hF0) begin
      n_err++; $display("FAIL async_reset uo=%h exp=3C uio=%h exp=00 oe=%h exp=F0", uo_out, uio_out, uio_oe);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, ret_q, 8'h03);
    step();
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, ret_q, 8'h03);
      n_vec++;
      if (uo_out !== exp_uo() || uio_out !== exp_uio()) begin
        n_err++; $display("FAIL post_reset cyc=%0d uo=%h exp=%h uio=%h exp=%h", cyc, uo_out, exp_uo(), uio_out, exp_uio());
      end
      step();
    end
  endtask

  initial begin
    build_seq();
    model_reset();
    test_reset();
    test_direct();
    test_registered();
    test_delayed();
    test_lfsr();
    test_stuck_and_clear();
    test_ena_hold();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tt_um_loopback_tester.md
Name: tt_um_loopback_tester

Overview:
Parametrised loopback and self-check user module for the multiplexer connectivity flow. It is the successor to the fixed combinational loopback. It adds selectable loopback modes: direct, registered, N-cycle delayed, and an LFSR generator with a checker. A saturating error counter is exposed on the bidirectional pins, so silicon and formal benches can measure path integrity and latency through the mux.

Parameters:
DELAY, 4, delay-line depth for mode 2; legal range 1..16.
LFSR_SEED, 8'h01, LFSR value after reset or after entering mode 3; must be non-zero.
LFSR_TAPS, 8'hB8, Galois feedback mask for the 8-bit LFSR.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  design enable from mux; all state frozen when 0
ui_in  input  8  dedicated inputs; loopback data or returned LFSR data
uo_out  output  8  dedicated outputs; loopback or LFSR data
uio_in  input  8  [1:0] mode select, [2] sync error clear, [7:3] ignored
uio_out  output  8  [7:4] error count, [3:0] constant 0
uio_oe  output  8  constant 8'hF0

Behaviour:
- All flops reset asynchronously on rst_n low. Reset values:
  - mode_q=0, delay line all 0, reg_q=0, lfsr=LFSR_SEED, chk_valid=0, err_cnt=0.
  - Resulting outputs: uo_out=ui_in (mode 0), uio_out=8'h00, uio_oe=8'hF0.
- State updates only on rising clk with ena=1. With ena=0 every register holds and outputs stay combinationally driven from held state.
- mode_q <= uio_in[1:0] each enabled cycle. A mode change takes effect one cycle after uio_in changes.
- Mode 0 (direct): uo_out = ui_in combinationally; zero latency.
- Mode 1 (registered): reg_q <= ui_in; uo_out = reg_q; latency 1.
- Mode 2 (delayed): uo_out = tap[DELAY-1]; latency DELAY cycles.
  - The delay line shifts ui_in in every enabled cycle in all modes, so mode 2 output is valid immediately on entry.
- Mode 3 (generator/checker):
  - uo_out = lfsr.
  - Each enabled cycle in mode 3: lfsr <= (lfsr>>1) ^ (lfsr[0] ? LFSR_TAPS : 0); lfsr_prev <= lfsr.
  - On the cycle mode_q becomes 3 from another mode: lfsr is loaded with LFSR_SEED, chk_valid <= 0.
  - Otherwise chk_valid <= 1 while in mode 3.
  - The external harness returns uo_out registered once, so the expected value is ui_in == lfsr_prev.
  - Check is performed when mode_q==3 and chk_valid==1. A mismatch increments err_cnt.
  - Leaving mode 3 clears chk_valid; lfsr holds.
- err_cnt:
  - 4 bits; saturates at 15, no wrap.
  - uio_in[2]=1 clears it synchronously; clear has priority over a same-cycle increment.
  - Persists across mode changes.
- uio_out[7:4] = err_cnt; uio_out[3:0] = 0.
- Reset mid-operation: all state returns to reset values immediately, with no clock needed.
- Parameter check: elaboration error if DELAY<1, DELAY>16, or LFSR_SEED==0.

Test Plan:
- Reset → uio_oe=F0, uio_out=00; ui_in=A5 in mode 0 → uo_out=A5 in the same cycle.
- Mode 1, ui_in sequence 11,22,33 → uo_out 11,22,33 each one cycle later.
- Mode 2 with DELAY=4, ui_in=5A for one cycle then 00 → uo_out=5A exactly 4 cycles later, for one cycle only.
- Mode 3 with ideal registered return path, 300 cycles → uo_out cycles through 255 distinct non-zero values; err_cnt stays 0.
- Mode 3, return path bit 0 stuck at 1 → err_cnt rises and saturates at F. Assert uio_in[2] with a simultaneous mismatch → err_cnt=0 the next cycle.
- ena=0 for 10 cycles mid-mode-3 → lfsr, err_cnt and delay line are unchanged. Re-assert ena → sequence resumes with no false error. Deassert rst_n mid-run → outputs return to reset values without a clock.
